exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk_i in 1 rising-edge clock; rst_i in 1 synchronous active-high reset.
REQ-002 SHALL have these inputs, all sampled only when in_valid_i & in_ready_o (the accept edge):
- in_valid_i in 1: an ID_EXE entry is present.
- instr_id_i in INST_ID_LEN: instruction ID, shared constants.
- rs1_val_i in 32: source operand A.
- rs2_val_i in 32: source operand B / store data.
- imm_i in 32: sign-extended immediate.
- rd_addr_i in 5: destination register.
- rd_we_i in 1: destination write enable.
- mem_we_i in 1: store.
REQ-003 SHALL have flush_i in 1: kill the accepted or in-flight instruction.
REQ-004 SHALL have these outputs:
- in_ready_o out 1: stage can accept.
- out_valid_o out 1: result registers valid, one-cycle pulse per instruction.
- alu_result_o out 32: result or memory address.
- store_data_o out 32: registered rs2_val_i.
- rd_addr_o out 5, rd_we_o out 1, mem_we_o out 1: registered controls.

Function
REQ-005 SHALL implement two states: IDLE and DIV; in_ready_o SHALL be 1 in IDLE and 0 in DIV (combinational from state).
REQ-006 Operand B SHALL be imm_i for I-type, load, store and LUI IDs, and rs2_val_i for R-type IDs.
REQ-007 Ops: ADD/ADDI, SUB, AND, OR, XOR, SLT, SLTU (signed/unsigned compare, result 0 or 1), SLL, SRL, SRA (shift amount = B[4:0]), LUI (result = imm_i), load/store (result = rs1 + imm, wrap mod 2^32).
REQ-008 MUL, MULH, MULHSU, MULHU SHALL complete in one cycle: low or high 32 bits of the 64-bit product with the named signedness.
REQ-009 Single-cycle ops: accepted in IDLE, all outputs load on the accept edge, out_valid_o = 1 for exactly the following cycle.
REQ-010 DIV, DIVU, REM, REMU with divisor != 0 and not signed overflow:
- Accept edge enters DIV, clears the 5-bit counter, latches magnitudes, signs and controls.
- Each DIV-state edge performs one restoring shift-subtract step.
- The edge with counter == 31 loads outputs, sets out_valid_o, and returns to IDLE.
- Outputs are therefore visible 32 cycles after the accept cycle.
REQ-011 Signed results: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-012 Divisor == 0: handled single-cycle with no DIV entry; quotient = 0xFFFFFFFF, remainder = dividend.
REQ-013 DIV/REM of 0x80000000 by 0xFFFFFFFF: single-cycle; quotient = 0x80000000, remainder = 0.
REQ-014 rd_we_o SHALL be forced to 0 whenever rd_addr = 0.
REQ-015 When no instruction is accepted and no division completes, out_valid_o SHALL be 0; the other outputs SHALL hold.
REQ-016 flush_i = 1 at an edge:
- Forces out_valid_o = 0, rd_we_o = 0 and mem_we_o = 0.
- In DIV, returns to IDLE with no result.
- Any same-edge input is not accepted.
- Flush takes priority over completion.
REQ-017 in_valid_i while in DIV SHALL be ignored; upstream holds the entry because in_ready_o = 0.

Reset
REQ-018 rst_i = 1 at an edge SHALL set state IDLE, counter 0, and all outputs 0 (in_ready_o = 1 after reset).
REQ-019 Reset SHALL have priority over flush_i and in_valid_i; reset mid-division SHALL abandon it with no out_valid_o pulse.

Verification
REQ-020 ADD, rs1 = 0x7FFFFFFF, rs2 = 1, rd = 5 -> next cycle alu_result_o = 0x80000000, rd_we_o = 1, out_valid_o pulse of 1 cycle.
REQ-021 SRA, rs1 = 0x80000000, rs2 = 0x24 -> alu_result_o = 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
REQ-022 DIV, rs1 = -7, rs2 = 2 -> in_ready_o = 0 for 32 cycles; out_valid_o 32 cycles after accept; result 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
REQ-023 DIVU by 0 -> 1 cycle, 0xFFFFFFFF; REM 0x80000000 by -1 -> 0, no DIV entry.
REQ-024 Flush at division cycle 10 -> no out_valid_o, in_ready_o = 1 next cycle; a following ADD completes normally.
REQ-025 Store with rs1 = 0x1000, imm = -4, rs2 = 0xAB, rd = 0 -> alu_result_o = 0xFFC, store_data_o = 0xAB, mem_we_o = 1, rd_we_o = 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU and multiplier, plus a 32-step restoring
// divider that stalls the upstream handshake while it iterates.

package exe_pkg;
    localparam int unsigned INST_ID_LEN = 5;

    // Instruction IDs shared with decode; R-type IDs occupy ID_ADD..ID_REMU.
    typedef enum logic [INST_ID_LEN-1:0] {
        ID_ADD, ID_SUB, ID_AND, ID_OR, ID_XOR, ID_SLT, ID_SLTU,
        ID_SLL, ID_SRL, ID_SRA,
        ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
        ID_DIV, ID_DIVU, ID_REM, ID_REMU,
        ID_ADDI, ID_ANDI, ID_ORI, ID_XORI, ID_SLTI, ID_SLTIU,
        ID_SLLI, ID_SRLI, ID_SRAI,
        ID_LUI, ID_LOAD, ID_STORE
    } inst_id_e;
endpackage

module exe_stage
    import exe_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    input  logic [INST_ID_LEN-1:0] instr_id_i,
    input  logic [31:0]            rs1_val_i,
    input  logic [31:0]            rs2_val_i,
    input  logic [31:0]            imm_i,
    input  logic [4:0]             rd_addr_i,
    input  logic                   rd_we_i,
    input  logic                   mem_we_i,
    input  logic                   flush_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic [31:0]            alu_result_o,
    output logic [31:0]            store_data_o,
    output logic [4:0]             rd_addr_o,
    output logic                   rd_we_o,
    output logic                   mem_we_o
);

    typedef enum logic {S_IDLE, S_DIV} state_e;

    state_e state_q, state_d;

    inst_id_e    id;
    logic        is_rtype;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        is_div;
    logic        div_signed;
    logic        div_is_rem;
    logic        div_start;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [63:0] prod;
    logic [31:0] div_mag_a;
    logic [31:0] div_mag_b;

    // Divider state latched on the accept edge
    logic [4:0]  cnt_q;
    logic [31:0] q_q;
    logic [31:0] r_q;
    logic [31:0] d_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        rem_q;
    logic [31:0] st_data_q;
    logic [4:0]  rd_addr_q;
    logic        rd_we_q;
    logic        mem_we_q;

    // Divider step results
    logic [32:0] r_sh;
    logic        sub_ok;
    logic [31:0] r_step;
    logic [31:0] q_step;
    logic [31:0] div_res;

    assign id         = inst_id_e'(instr_id_i);
    assign in_ready_o = (state_q == S_IDLE);

    // Operand selection, single-cycle result and divide classification
    always_comb begin
        is_rtype   = 1'b0;
        alu_res    = '0;
        is_div     = 1'b0;
        div_signed = (id == ID_DIV) || (id == ID_REM);
        div_is_rem = (id == ID_REM) || (id == ID_REMU);
        mul_a      = {(id == ID_MULH || id == ID_MULHSU) & rs1_val_i[31], rs1_val_i};
        mul_b      = {(id == ID_MULH) & rs2_val_i[31], rs2_val_i};
        prod       = 64'($signed(mul_a) * $signed(mul_b));
        case (id)
            ID_ADD, ID_SUB, ID_AND, ID_OR, ID_XOR, ID_SLT, ID_SLTU,
            ID_SLL, ID_SRL, ID_SRA, ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
            ID_DIV, ID_DIVU, ID_REM, ID_REMU: is_rtype = 1'b1;
            default: is_rtype = 1'b0;
        endcase
        op_b = is_rtype ? rs2_val_i : imm_i;
        case (id)
            ID_ADD, ID_ADDI, ID_LOAD, ID_STORE: alu_res = rs1_val_i + op_b;
            ID_SUB:            alu_res = rs1_val_i - op_b;
            ID_AND, ID_ANDI:   alu_res = rs1_val_i & op_b;
            ID_OR, ID_ORI:     alu_res = rs1_val_i | op_b;
            ID_XOR, ID_XORI:   alu_res = rs1_val_i ^ op_b;
            ID_SLT, ID_SLTI:   alu_res = {31'b0, $signed(rs1_val_i) < $signed(op_b)};
            ID_SLTU, ID_SLTIU: alu_res = {31'b0, rs1_val_i < op_b};
            ID_SLL, ID_SLLI:   alu_res = rs1_val_i << op_b[4:0];
            ID_SRL, ID_SRLI:   alu_res = rs1_val_i >> op_b[4:0];
            ID_SRA, ID_SRAI:   alu_res = 32'($signed(rs1_val_i) >>> op_b[4:0]);
            ID_LUI:            alu_res = imm_i;
            ID_MUL:            alu_res = prod[31:0];
            ID_MULH, ID_MULHSU, ID_MULHU: alu_res = prod[63:32];
            ID_DIV, ID_DIVU, ID_REM, ID_REMU: begin
                is_div = 1'b1;
                // Zero divisor and signed overflow resolve here without iterating
                if (rs2_val_i == '0)
                    alu_res = div_is_rem ? rs1_val_i : '1;
                else
                    alu_res = div_is_rem ? '0 : 32'h8000_0000;
            end
            default: alu_res = '0;
        endcase
        div_start = is_div && (rs2_val_i != '0) &&
                    !(div_signed && rs1_val_i == 32'h8000_0000 && rs2_val_i == '1);
        div_mag_a = (div_signed && rs1_val_i[31]) ? (32'd0 - rs1_val_i) : rs1_val_i;
        div_mag_b = (div_signed && rs2_val_i[31]) ? (32'd0 - rs2_val_i) : rs2_val_i;
    end

    // One restoring shift-subtract step and sign fix-up of the final step
    always_comb begin
        r_sh    = {r_q, q_q[31]};
        sub_ok  = (r_sh >= {1'b0, d_q});
        r_step  = sub_ok ? 32'(r_sh - {1'b0, d_q}) : r_sh[31:0];
        q_step  = {q_q[30:0], sub_ok};
        if (rem_q)
            div_res = r_neg_q ? (32'd0 - r_step) : r_step;
        else
            div_res = q_neg_q ? (32'd0 - q_step) : q_step;
    end

    // FSM next state: enter DIV on an iterating divide, leave on flush or last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid_i && !flush_i && div_start) state_d = S_DIV;
            S_DIV:  if (flush_i || cnt_q == 5'd31) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Output registers and divider datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            alu_result_o <= '0;
            store_data_o <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            mem_we_o     <= 1'b0;
            cnt_q        <= '0;
            q_q          <= '0;
            r_q          <= '0;
            d_q          <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            rem_q        <= 1'b0;
            st_data_q    <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            if (flush_i) begin
                rd_we_o  <= 1'b0;
                mem_we_o <= 1'b0;
            end else if (state_q == S_IDLE && in_valid_i) begin
                if (div_start) begin
                    cnt_q     <= '0;
                    q_q       <= div_mag_a;
                    r_q       <= '0;
                    d_q       <= div_mag_b;
                    q_neg_q   <= div_signed && (rs1_val_i[31] ^ rs2_val_i[31]);
                    r_neg_q   <= div_signed && rs1_val_i[31];
                    rem_q     <= div_is_rem;
                    st_data_q <= rs2_val_i;
                    rd_addr_q <= rd_addr_i;
                    rd_we_q   <= rd_we_i && (rd_addr_i != '0);
                    mem_we_q  <= mem_we_i;
                end else begin
                    out_valid_o  <= 1'b1;
                    alu_result_o <= alu_res;
                    store_data_o <= rs2_val_i;
                    rd_addr_o    <= rd_addr_i;
                    rd_we_o      <= rd_we_i && (rd_addr_i != '0);
                    mem_we_o     <= mem_we_i;
                end
            end else if (state_q == S_DIV) begin
                cnt_q <= cnt_q + 5'd1;
                q_q   <= q_step;
                r_q   <= r_step;
                if (cnt_q == 5'd31) begin
                    out_valid_o  <= 1'b1;
                    alu_result_o <= div_res;
                    store_data_o <= st_data_q;
                    rd_addr_o    <= rd_addr_q;
                    rd_we_o      <= rd_we_q;
                    mem_we_o     <= mem_we_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for single-cycle ops, hand
// sequences for division latency, stalls, flush and reset.

module tb_exe_stage;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic [4:0]  instr_id_i;
    logic [31:0] rs1_val_i, rs2_val_i, imm_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i, mem_we_i, flush_i;
    logic        in_ready_o, out_valid_o;
    logic [31:0] alu_result_o, store_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, mem_we_o;

    int total = 0;
    int bad   = 0;

    exe_stage dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .instr_id_i(instr_id_i),
        .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .imm_i(imm_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .mem_we_i(mem_we_i), .flush_i(flush_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .alu_result_o(alu_result_o),
        .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
        .mem_we_o(mem_we_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        inst_id_e    id;
        logic [31:0] rs1, rs2, imm;
        logic [4:0]  rd;
        logic        rd_we, mem_we;
        logic [31:0] exp_res;
        logic        exp_rd_we, exp_mem_we;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input inst_id_e id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic we, input logic mwe);
        instr_id_i = id;
        rs1_val_i  = a;
        rs2_val_i  = b;
        imm_i      = imm;
        rd_addr_i  = rd;
        rd_we_i    = we;
        mem_we_i   = mwe;
    endtask

    // Wait (bounded) for an out_valid pulse; counts stalled samples before it
    task automatic wait_result(output int lat, output int busy, output logic got);
        lat  = 0;
        busy = 0;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (!in_ready_o) busy++;
            @(posedge clk); #1;
            lat++;
            if (out_valid_o) got = 1'b1;
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) pulses++;
        end
    endtask

    initial begin
        int   lat, busy, pulses;
        logic got;

        vecs[0]  = '{"add_ovf",  ID_ADD,    32'h7FFFFFFF, 32'h1,        32'h100,      5'd5, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0};
        vecs[1]  = '{"sub",      ID_SUB,    32'h5,        32'h7,        32'h0,        5'd6, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[2]  = '{"and",      ID_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd7, 1'b1, 1'b0, 32'h00F000F0, 1'b1, 1'b0};
        vecs[3]  = '{"or",       ID_OR,     32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd7, 1'b1, 1'b0, 32'hFFF0FFF0, 1'b1, 1'b0};
        vecs[4]  = '{"xor",      ID_XOR,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        5'd7, 1'b1, 1'b0, 32'hFF00FF00, 1'b1, 1'b0};
        vecs[5]  = '{"slt",      ID_SLT,    32'hFFFFFFFF, 32'h1,        32'h0,        5'd1, 1'b1, 1'b0, 32'h1,        1'b1, 1'b0};
        vecs[6]  = '{"sltu",     ID_SLTU,   32'h1,        32'hFFFFFFFF, 32'h0,        5'd1, 1'b1, 1'b0, 32'h1,        1'b1, 1'b0};
        vecs[7]  = '{"sltu_neg", ID_SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        5'd1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[8]  = '{"sll",      ID_SLL,    32'h1,        32'h21,       32'h0,        5'd2, 1'b1, 1'b0, 32'h2,        1'b1, 1'b0};
        vecs[9]  = '{"srl",      ID_SRL,    32'h80000000, 32'h24,       32'h0,        5'd2, 1'b1, 1'b0, 32'h08000000, 1'b1, 1'b0};
        vecs[10] = '{"sra",      ID_SRA,    32'h80000000, 32'h24,       32'h0,        5'd2, 1'b1, 1'b0, 32'hF8000000, 1'b1, 1'b0};
        vecs[11] = '{"addi",     ID_ADDI,   32'hA,        32'h55,       32'hFFFFFFFD, 5'd3, 1'b1, 1'b0, 32'h7,        1'b1, 1'b0};
        vecs[12] = '{"slti",     ID_SLTI,   32'hFFFFFFFE, 32'h0,        32'h1,        5'd3, 1'b1, 1'b0, 32'h1,        1'b1, 1'b0};
        vecs[13] = '{"sltiu",    ID_SLTIU,  32'h5,        32'h0,        32'hFFFFFFFF, 5'd3, 1'b1, 1'b0, 32'h1,        1'b1, 1'b0};
        vecs[14] = '{"srai",     ID_SRAI,   32'hF0000000, 32'h0,        32'h4,        5'd3, 1'b1, 1'b0, 32'hFF000000, 1'b1, 1'b0};
        vecs[15] = '{"lui",      ID_LUI,    32'hDEADBEEF, 32'h0,        32'h12345000, 5'd4, 1'b1, 1'b0, 32'h12345000, 1'b1, 1'b0};
        vecs[16] = '{"load",     ID_LOAD,   32'h1000,     32'h0,        32'h10,       5'd8, 1'b1, 1'b0, 32'h1010,     1'b1, 1'b0};
        vecs[17] = '{"store",    ID_STORE,  32'h1000,     32'hAB,       32'hFFFFFFFC, 5'd0, 1'b1, 1'b1, 32'hFFC,      1'b0, 1'b1};
        vecs[18] = '{"mul",      ID_MUL,    32'hFFFFFFFF, 32'h2,        32'h0,        5'd9, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[19] = '{"mulh",     ID_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd9, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[20] = '{"mulhsu",   ID_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd9, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[21] = '{"mulhsu2",  ID_MULHSU, 32'h2,        32'hFFFFFFFF, 32'h0,        5'd9, 1'b1, 1'b0, 32'h1,        1'b1, 1'b0};
        vecs[22] = '{"mulhu",    ID_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd9, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[23] = '{"divu_by0", ID_DIVU,   32'h1234,     32'h0,        32'h0,        5'd10, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[24] = '{"remu_by0", ID_REMU,   32'h1234,     32'h0,        32'h0,        5'd10, 1'b1, 1'b0, 32'h1234,     1'b1, 1'b0};
        vecs[25] = '{"div_by0",  ID_DIV,    32'hFFFFFFF9, 32'h0,        32'h0,        5'd10, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[26] = '{"rem_ovf",  ID_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        5'd11, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[27] = '{"div_ovf",  ID_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h0,        5'd11, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0};

        rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0;
        drive(ID_ADD, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'h0);
        chk("rst_result", alu_result_o, 32'h0);
        chk("rst_store", store_data_o, 32'h0);
        chk("rst_rd_we", {31'b0, rd_we_o}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready_o}, 32'h1);

        // Flush on the same edge as a valid entry: nothing accepted
        drive(ID_ADD, 32'h5, 32'h5, 32'h0, 5'd1, 1'b1, 1'b0);
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_acc_valid", {31'b0, out_valid_o}, 32'h0);
        chk("flush_acc_result", alu_result_o, 32'h0);
        chk("flush_acc_ready", {31'b0, in_ready_o}, 32'h1);

        foreach (vecs[i]) begin
            drive(vecs[i].id, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].rd,
                  vecs[i].rd_we, vecs[i].mem_we);
            in_valid_i = 1'b1;
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            chk({vecs[i].name, "_valid"},  {31'b0, out_valid_o}, 32'h1);
            chk({vecs[i].name, "_result"}, alu_result_o, vecs[i].exp_res);
            chk({vecs[i].name, "_store"},  store_data_o, vecs[i].rs2);
            chk({vecs[i].name, "_rd"},     {27'b0, rd_addr_o}, {27'b0, vecs[i].rd});
            chk({vecs[i].name, "_rd_we"},  {31'b0, rd_we_o}, {31'b0, vecs[i].exp_rd_we});
            chk({vecs[i].name, "_mem_we"}, {31'b0, mem_we_o}, {31'b0, vecs[i].exp_mem_we});
            chk({vecs[i].name, "_ready"},  {31'b0, in_ready_o}, 32'h1);
            @(posedge clk); #1;
            chk({vecs[i].name, "_pulse_end"}, {31'b0, out_valid_o}, 32'h0);
            chk({vecs[i].name, "_hold"}, alu_result_o, vecs[i].exp_res);
        end

        // DIV -7 / 2: 32 stalled cycles, result -3
        drive(ID_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 5'd3, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("div_no_early_valid", {31'b0, out_valid_o}, 32'h0);
        wait_result(lat, busy, got);
        chk("div_got", {31'b0, got}, 32'h1);
        chk("div_latency", lat, 32);
        chk("div_busy", busy, 32);
        chk("div_result", alu_result_o, 32'hFFFFFFFD);
        chk("div_rd", {27'b0, rd_addr_o}, 32'd3);
        chk("div_rd_we", {31'b0, rd_we_o}, 32'h1);
        chk("div_ready_after", {31'b0, in_ready_o}, 32'h1);

        // REM -7 / 2 with a held ADD upstream that must wait for the divider
        drive(ID_REM, 32'hFFFFFFF9, 32'h2, 32'h0, 5'd9, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        drive(ID_ADD, 32'h1, 32'h1, 32'h0, 5'd4, 1'b1, 1'b0);
        wait_result(lat, busy, got);
        chk("rem_got", {31'b0, got}, 32'h1);
        chk("rem_latency", lat, 32);
        chk("rem_result", alu_result_o, 32'hFFFFFFFF);
        chk("rem_rd", {27'b0, rd_addr_o}, 32'd9);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("held_add_valid", {31'b0, out_valid_o}, 32'h1);
        chk("held_add_result", alu_result_o, 32'h2);
        chk("held_add_rd", {27'b0, rd_addr_o}, 32'd4);

        // Unsigned divide of a large dividend
        drive(ID_DIVU, 32'hFFFFFFFF, 32'hA, 32'h0, 5'd12, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        wait_result(lat, busy, got);
        chk("divu_got", {31'b0, got}, 32'h1);
        chk("divu_result", alu_result_o, 32'h19999999);

        drive(ID_REMU, 32'hFFFFFFFF, 32'hA, 32'h0, 5'd12, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        wait_result(lat, busy, got);
        chk("remu_got", {31'b0, got}, 32'h1);
        chk("remu_result", alu_result_o, 32'h5);

        // Flush at division cycle 10
        drive(ID_DIVU, 32'd100, 32'd7, 32'h0, 5'd6, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush_pre_ready", {31'b0, in_ready_o}, 32'h0);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_valid", {31'b0, out_valid_o}, 32'h0);
        chk("flush_ready", {31'b0, in_ready_o}, 32'h1);
        chk("flush_rd_we", {31'b0, rd_we_o}, 32'h0);
        count_pulses(40, pulses);
        chk("flush_no_pulse", pulses, 0);
        drive(ID_ADD, 32'h3, 32'h4, 32'h0, 5'd2, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("post_flush_valid", {31'b0, out_valid_o}, 32'h1);
        chk("post_flush_result", alu_result_o, 32'h7);
        chk("post_flush_rd_we", {31'b0, rd_we_o}, 32'h1);

        // Reset mid-division abandons it
        drive(ID_DIV, 32'd100, 32'd7, 32'h0, 5'd6, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("midrst_valid", {31'b0, out_valid_o}, 32'h0);
        chk("midrst_result", alu_result_o, 32'h0);
        chk("midrst_rd_we", {31'b0, rd_we_o}, 32'h0);
        chk("midrst_ready", {31'b0, in_ready_o}, 32'h1);
        count_pulses(40, pulses);
        chk("midrst_no_pulse", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
